// File: rtl/ifid_fetch_buffer.sv
// Two-entry fetch/decode skid buffer with flush and sticky HALT latch.
// Optional macro IFID_BYPASS_EN: an empty buffer forwards if_* to id_* in the same cycle.
module ifid_fetch_buffer #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] NOP_INSTR = 16'h0800
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_if_valid,
  input  logic [WIDTH-1:0] i_if_instr,
  input  logic [WIDTH-1:0] i_if_pc,
  input  logic [WIDTH-1:0] i_if_pc2,
  output logic             o_if_ready,
  input  logic             i_flush,
  input  logic             i_id_ready,
  output logic             o_id_valid,
  output logic [WIDTH-1:0] o_id_instr,
  output logic [WIDTH-1:0] o_id_pc,
  output logic [WIDTH-1:0] o_id_pc2,
  output logic [1:0]       o_count,
  output logic             o_halted
);

  logic [WIDTH-1:0] r_instr [0:1];
  logic [WIDTH-1:0] r_pc    [0:1];
  logic [WIDTH-1:0] r_pc2   [0:1];
  logic             r_rptr;
  logic             r_wptr;
  logic [1:0]       r_count;
  logic             r_halted;

  logic             w_bypass;
  logic             w_valid;
  logic [WIDTH-1:0] w_head_instr;
  logic [WIDTH-1:0] w_head_pc;
  logic [WIDTH-1:0] w_head_pc2;
  logic             w_push;
  logic             w_pop;
  logic             w_write;
  logic             w_read;
  logic             w_halt_pop;

  assign o_if_ready = ~r_halted & (r_count != 2'd2);

`ifdef IFID_BYPASS_EN
  assign w_bypass = (r_count == 2'd0) & i_if_valid & ~i_flush & ~r_halted;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_valid      = (~r_halted & (r_count != 2'd0)) | w_bypass;
  assign w_head_instr = w_bypass ? i_if_instr : r_instr[r_rptr];
  assign w_head_pc    = w_bypass ? i_if_pc    : r_pc[r_rptr];
  assign w_head_pc2   = w_bypass ? i_if_pc2   : r_pc2[r_rptr];

  assign w_push     = i_if_valid & o_if_ready & ~i_flush;
  assign w_pop      = w_valid & i_id_ready & ~i_flush;
  // A bypassed word consumed in the same cycle never touches storage.
  assign w_write    = w_push & ~(w_bypass & w_pop);
  assign w_read     = w_pop & ~w_bypass;
  assign w_halt_pop = w_pop & (w_head_instr[WIDTH-1 -: 5] == 5'b00000);

  assign o_id_valid = w_valid;
  assign o_id_instr = w_valid ? w_head_instr : NOP_INSTR;
  assign o_id_pc    = w_valid ? w_head_pc    : '0;
  assign o_id_pc2   = w_valid ? w_head_pc2   : '0;
  assign o_count    = r_count;
  assign o_halted   = r_halted;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < 2; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
        r_pc2[i]   <= '0;
      end
      r_rptr   <= 1'b0;
      r_wptr   <= 1'b0;
      r_count  <= 2'd0;
      r_halted <= 1'b0;
    end else if (i_flush && !r_halted) begin
      r_rptr  <= 1'b0;
      r_wptr  <= 1'b0;
      r_count <= 2'd0;
    end else if (w_halt_pop) begin
      // Younger entries and any same-cycle push die with the HALT.
      r_halted <= 1'b1;
      r_count  <= 2'd0;
      r_rptr   <= 1'b0;
      r_wptr   <= 1'b0;
    end else begin
      if (w_write) begin
        r_instr[r_wptr] <= i_if_instr;
        r_pc[r_wptr]    <= i_if_pc;
        r_pc2[r_wptr]   <= i_if_pc2;
        r_wptr          <= ~r_wptr;
      end
      if (w_read) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, w_write} - {1'b0, w_read};
    end
  end

endmodule

// File: tb/tb_ifid_fetch_buffer.sv
// Scoreboard bench for ifid_fetch_buffer: expected entries queued on accepted pushes, compared on pops.
module tb_ifid_fetch_buffer;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc2;
  } ent_t;

`ifdef IFID_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_valid = 1'b0;
  logic [15:0] if_instr = '0;
  logic [15:0] if_pc = '0;
  logic [15:0] if_pc2 = '0;
  logic        if_ready;
  logic        flush = 1'b0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic [15:0] id_pc2;
  logic [1:0]  count;
  logic        halted;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t sb_q[$];
  bit   exp_halted = 1'b0;

  ifid_fetch_buffer #(.WIDTH(16), .NOP_INSTR(16'h0800)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_if_valid (if_valid),
    .i_if_instr (if_instr),
    .i_if_pc    (if_pc),
    .i_if_pc2   (if_pc2),
    .o_if_ready (if_ready),
    .i_flush    (flush),
    .i_id_ready (id_ready),
    .o_id_valid (id_valid),
    .o_id_instr (id_instr),
    .o_id_pc    (id_pc),
    .o_id_pc2   (id_pc2),
    .o_count    (count),
    .o_halted   (halted)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Compare outputs against the scoreboard, then advance the model across the coming edge.
  task automatic check_and_model();
    bit   byp;
    bit   exp_valid;
    bit   exp_ready;
    bit   pop;
    bit   push;
    ent_t head;
    logic [15:0] hi;
    byp       = BYP && (sb_q.size() == 0) && if_valid && !flush && !exp_halted;
    exp_valid = !exp_halted && ((sb_q.size() != 0) || byp);
    exp_ready = !exp_halted && (sb_q.size() != 2);
    head      = byp ? ent_t'({if_instr, if_pc, if_pc2}) : ((sb_q.size() != 0) ? sb_q[0] : ent_t'(48'd0));
    check_val("if_ready", 32'(if_ready), 32'(exp_ready));
    check_val("id_valid", 32'(id_valid), 32'(exp_valid));
    check_val("count", 32'(count), byp ? 32'd0 : 32'(sb_q.size()));
    check_val("halted", 32'(halted), 32'(exp_halted));
    if (exp_valid) begin
      check_val("id_instr", 32'(id_instr), 32'(head.instr));
      check_val("id_pc", 32'(id_pc), 32'(head.pc));
      check_val("id_pc2", 32'(id_pc2), 32'(head.pc2));
    end else begin
      check_val("id_instr_nop", 32'(id_instr), 32'h0800);
      check_val("id_pc_zero", 32'(id_pc), 32'd0);
      check_val("id_pc2_zero", 32'(id_pc2), 32'd0);
    end
    pop  = exp_valid && id_ready && !flush;
    push = if_valid && exp_ready && !flush;
    if (pop) $display("pop instr=%h pc=%h pc2=%h", head.instr, head.pc, head.pc2);
    if (flush && !exp_halted) begin
      sb_q.delete();
    end else begin
      hi = head.instr;
      if (pop && hi[15:11] == 5'b00000) begin
        exp_halted = 1'b1;
        sb_q.delete();
      end else begin
        if (pop && !byp) void'(sb_q.pop_front());
        if (push && !(pop && byp)) begin
          sb_q.push_back('{if_instr, if_pc, if_pc2});
          $display("push instr=%h pc=%h pc2=%h", if_instr, if_pc, if_pc2);
        end
      end
    end
  endtask

  task automatic cycle(input logic iv, input logic [15:0] ins, input logic [15:0] pc,
                       input logic idr, input logic fl);
    if_valid = iv;
    if_instr = ins;
    if_pc    = pc;
    if_pc2   = pc + 16'd2;
    id_ready = idr;
    flush    = fl;
    @(negedge clk);
    check_and_model();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_valid"}, 32'(id_valid), 32'd0);
    check_val({tag, "_instr"}, 32'(id_instr), 32'h0800);
    check_val({tag, "_pc"}, 32'(id_pc), 32'd0);
    check_val({tag, "_pc2"}, 32'(id_pc2), 32'd0);
    check_val({tag, "_ready"}, 32'(if_ready), 32'd1);
    check_val({tag, "_count"}, 32'(count), 32'd0);
    check_val({tag, "_halted"}, 32'(halted), 32'd0);
  endtask

  task automatic apply_reset(input string tag);
    if_valid = 1'b0;
    flush    = 1'b0;
    id_ready = 1'b0;
    rst      = 1'b0;
    #1;
    sb_q.delete();
    exp_halted = 1'b0;
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    check_reset_outputs({tag, "_held"});
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset streaming
    @(posedge clk);
    #1;
    apply_reset("rst");
    cycle(1, 16'h4001, 16'h0000, 1, 0);
    cycle(1, 16'h4002, 16'h0002, 1, 0);
    cycle(0, 16'h0000, 16'h0000, 1, 0);
    cycle(0, 16'h0000, 16'h0000, 1, 0);

    // Stall fill: third word refused, then drain in order
    cycle(1, 16'h5001, 16'h0010, 0, 0);
    cycle(1, 16'h5002, 16'h0012, 0, 0);
    cycle(1, 16'h5003, 16'h0014, 0, 0);
    check_val("stall_full_count", 32'(count), 32'd2);
    check_val("stall_full_ready", 32'(if_ready), 32'd0);
    cycle(0, 16'h0000, 16'h0000, 1, 0);
    check_val("stall_ready_back", 32'(if_ready), 32'd1);
    cycle(0, 16'h0000, 16'h0000, 1, 0);
    cycle(0, 16'h0000, 16'h0000, 1, 0);

    // Simultaneous push/pop at count=1 across pointer wrap
    cycle(1, 16'h5100, 16'h0020, 0, 0);
    for (int i = 1; i <= 6; i++)
      cycle(1, 16'h5100 + 16'(i), 16'h0020 + 16'(2 * i), 1, 0);
    cycle(0, 16'h0000, 16'h0000, 1, 0);
    cycle(0, 16'h0000, 16'h0000, 1, 0);

    // Flush with a full buffer; 6A05 is discarded
    cycle(1, 16'h5201, 16'h0040, 0, 0);
    cycle(1, 16'h5202, 16'h0042, 0, 0);
    cycle(1, 16'h6A05, 16'h0044, 0, 1);
    check_val("flush_count", 32'(count), 32'd0);
    check_val("flush_valid", 32'(id_valid), 32'd0);
    check_val("flush_instr", 32'(id_instr), 32'h0800);
    cycle(1, 16'h5300, 16'h0100, 1, 0);
    cycle(0, 16'h0000, 16'h0000, 1, 0);
    cycle(0, 16'h0000, 16'h0000, 1, 0);

    // Mid-stream asynchronous reset drops entries without an edge
    cycle(1, 16'h5401, 16'h0200, 0, 0);
    cycle(1, 16'h5402, 16'h0202, 0, 0);
    #2;
    apply_reset("rst_mid");
    cycle(0, 16'h0000, 16'h0000, 1, 0);

    // HALT: younger 4003 never emerges, flush ignored, reset clears
    cycle(1, 16'h0000, 16'h0300, 0, 0);
    cycle(1, 16'h4003, 16'h0302, 0, 0);
    cycle(1, 16'h4004, 16'h0304, 1, 0);
    check_val("halt_flag", 32'(halted), 32'd1);
    check_val("halt_count", 32'(count), 32'd0);
    check_val("halt_ready", 32'(if_ready), 32'd0);
    cycle(1, 16'h4005, 16'h0306, 1, 1);
    cycle(0, 16'h0000, 16'h0000, 1, 0);
    check_val("halt_sticky", 32'(halted), 32'd1);
    apply_reset("rst_halt");
    cycle(1, 16'h4006, 16'h0400, 1, 0);
    cycle(0, 16'h0000, 16'h0000, 1, 0);

    // Empty-buffer push with decode ready (0-latency only with bypass)
    cycle(1, 16'h4001, 16'h0000, 1, 0);
    cycle(0, 16'h0000, 16'h0000, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
